result_writeback: RTL
=====================

# result_writeback

Downstream stage of the 4x4 systolic array with memory and controller. It snapshots the 16 signed results when the array pulses `done`, then drains them in row-major order. Each result goes into an internal result memory at `base_addr + idx`, gated by `save_into_memory`, and also out on a valid/ready stream. A registered host read port returns stored results.

## Interface

**Parameters**
- `DATA_W`, 16: signed result width.
- `N`, 4: array dimension; `N*N` results per job.
- `ADDR_W`, 8: result-memory address width; depth is `2**ADDR_W`.

**Ports**
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `done_i` in 1: one-cycle completion pulse from the array.
- `res_i` in `N*N*DATA_W`: flattened results; element (i,j) sits at slice index `i*N+j` (r_00 at bits [15:0]).
- `base_addr` in `ADDR_W`: result-memory start address, sampled on accepted `done_i`.
- `save_into_memory` in 1: memory-write enable for the job, sampled on accepted `done_i`.
- `m_valid` out 1: stream element valid.
- `m_ready` in 1: stream consumer ready.
- `m_data` out `DATA_W`: stream element.
- `m_last` out 1: high with element 15.
- `rd_addr` in `ADDR_W`: host read address.
- `rd_data` out `DATA_W`: host read data, registered.
- `busy` out 1: high in DRAIN and FINISH.
- `wb_done` out 1: one-cycle pulse when a job completes.
- `overflow` out 1: sticky flag for a dropped `done_i`.

## Operation

**FSM states:** IDLE, DRAIN, FINISH.
- **IDLE + `done_i`:**
  - Copy `res_i` into a 16-entry snapshot buffer.
  - Latch `base_addr` and `save_into_memory`.
  - Clear `idx` to 0 and go to DRAIN.
- **DRAIN:**
  - `m_valid`=1, `m_data`=snap[idx], `m_last`=(idx==N*N-1).
  - An element advances when `m_valid && m_ready`.
  - On advance with latched save=1: write mem[(base+idx) mod 2**ADDR_W] = snap[idx].
  - On advancing element 15, go to FINISH; otherwise increment `idx`.
- **FINISH:** `wb_done`=1 for one cycle, then go to IDLE.

**Boundary rules**
- `done_i` outside IDLE (DRAIN or FINISH) is dropped: snapshot untouched, `overflow` set to 1. `overflow` clears only on reset.
- Address wraps: base=250 writes addresses 250..255, then 0..9.
- `res_i`, `base_addr` and `save_into_memory` changing after capture have no effect on the current job.
- `m_valid` does not drop while waiting for `m_ready`. `m_data` is stable while `m_valid && !m_ready`.
- Host read and memory write to the same address in the same cycle: read-first, so `rd_data` returns the old value.
- Arithmetic: results pass through unchanged (no width change or saturation). The address add is unsigned modulo `2**ADDR_W`.
- Reset mid-drain:
  - State returns to IDLE and the remaining elements are discarded.
  - Memory contents are not cleared; already-written entries persist.

**Reset values:** `m_valid`=0, `m_data`=0, `m_last`=0, `rd_data`=0, `busy`=0, `wb_done`=0, `overflow`=0, `idx`=0.

## Timing

- `done_i` sampled at edge T: `m_valid`=1 and `busy`=1 after edge T.
- With `m_ready` held at 1:
  - Elements 0..15 transfer on edges T+1..T+16.
  - `wb_done` is high between edges T+16 and T+17.
  - `busy` falls after edge T+17.
- Each low-`m_ready` cycle adds exactly one cycle of latency.
- A new `done_i` is accepted no earlier than edge T+17 (IDLE again).
- Memory write commits on the handshake edge. `rd_data` reflects `rd_addr` one edge later.

## Configuration

- **`WB_STREAM_EN` defined:**
  - Stream port is active and `m_ready` gates advance, as above.
- **`WB_STREAM_EN` undefined:**
  - `m_valid`, `m_data` and `m_last` are tied to 0 and `m_ready` is ignored.
  - One element advances every DRAIN cycle, so a job takes exactly 16 DRAIN cycles and `wb_done` is high between edges T+16 and T+17.

## Test plan

- **Basic drain:** `res_i` elements = 1..16, base=0, save=1, `m_ready`=1 -> stream 1..16 on edges T+1..T+16, `m_last` with 16, `wb_done` after edge T+16; `rd_addr`=5 -> `rd_data`=6.
- **Back-pressure:** `m_ready` low for 3 cycles at idx=4 -> `m_data` holds 5 with `m_valid`=1, no write to mem[4] until the handshake, `wb_done` 3 cycles later.
- **Wrap:** base=250, results 100..115 -> mem[255]=105, mem[0]=106, mem[9]=115.
- **save=0:** preload mem[0..15]=0x7FFF, run a job -> stream correct, memory unchanged at 0x7FFF; result -5 streams as 0xFFFB.
- **Overflow:** second `done_i` at T+5 -> `overflow`=1 (sticky), first job's data streams intact, no second job starts.
- **Reset mid-drain:** assert `rst` after 7 transfers -> `busy`=0, `m_valid`=0, mem[0..6] retain values, mem[7..15] unwritten; a new `done_i` starts cleanly at idx 0.

Source files
------------

// File: rtl/result_writeback.sv
// result_writeback: downstream stage of the 4x4 systolic array.
// Snapshots the N*N signed results on an accepted done_i pulse, then drains them in
// row-major order into an internal result memory (at base_addr + idx, when
// save_into_memory was set) and onto a valid/ready stream. A registered host read port
// returns stored results.
//
// Optional feature macro: WB_STREAM_EN
//   defined   - stream port active, m_ready gates each element.
//   undefined - m_valid/m_data/m_last tied to 0, m_ready ignored, one element per cycle.
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   done_i            - one-cycle completion pulse from the array
//   res_i             - flattened results, element (i,j) at slice i*N+j
//   base_addr         - result-memory start address (sampled on accept)
//   save_into_memory  - memory-write enable for the job (sampled on accept)
//   m_valid/m_ready/m_data/m_last - result stream, m_last with the final element
//   rd_addr/rd_data   - host read port, one-cycle registered read
//   busy              - job in DRAIN or FINISH
//   wb_done           - one-cycle pulse on job completion
//   overflow          - sticky: a done_i arrived while busy and was dropped
module result_writeback #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N      = 4,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     done_i,
  input  logic [N*N*DATA_W-1:0]    res_i,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic                     save_into_memory,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_W-1:0]        m_data,
  output logic                     m_last,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     busy,
  output logic                     wb_done,
  output logic                     overflow
);

  localparam int unsigned NumEl = N * N;
  localparam int unsigned IdxW  = $clog2(NumEl);
  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StDrain, StFinish} state_e;

  state_e              state_q;
  logic [IdxW-1:0]     idx_q;
  logic [ADDR_W-1:0]   base_q;
  logic                save_q;
  logic                busy_q;
  logic                wb_done_q;
  logic                overflow_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic [DATA_W-1:0]   snap_q [NumEl];
  logic [DATA_W-1:0]   mem [Depth];

  logic                accept;
  logic                adv;
  logic                last_el;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;

`ifdef WB_STREAM_EN
  logic                m_valid_q;
  logic                m_last_q;
  logic [DATA_W-1:0]   m_data_q;

  assign adv     = m_valid_q & m_ready;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
`else
  logic unused_m_ready;
  assign unused_m_ready = m_ready;

  // Without a stream consumer every DRAIN cycle retires one element.
  assign adv     = 1'b1;
  assign m_valid = 1'b0;
  assign m_data  = '0;
  assign m_last  = 1'b0;
`endif

  assign accept  = (state_q == StIdle) && done_i;
  assign last_el = (idx_q == IdxW'(NumEl - 1));
  assign wr_en   = (state_q == StDrain) && adv && save_q;
  // Unsigned add wraps modulo the memory depth.
  assign wr_addr = base_q + ADDR_W'(idx_q);

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      base_q     <= '0;
      save_q     <= 1'b0;
      busy_q     <= 1'b0;
      wb_done_q  <= 1'b0;
      overflow_q <= 1'b0;
`ifdef WB_STREAM_EN
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
`endif
    end else begin
      wb_done_q <= 1'b0;
      if (done_i && (state_q != StIdle)) overflow_q <= 1'b1;
      case (state_q)
        StIdle: begin
          if (done_i) begin
            state_q   <= StDrain;
            idx_q     <= '0;
            base_q    <= base_addr;
            save_q    <= save_into_memory;
            busy_q    <= 1'b1;
`ifdef WB_STREAM_EN
            // Snapshot is written this same edge, so present element 0 from the input.
            m_valid_q <= 1'b1;
            m_data_q  <= res_i[DATA_W-1:0];
            m_last_q  <= (NumEl == 1);
`endif
          end
        end
        StDrain: begin
          if (adv) begin
            if (last_el) begin
              state_q   <= StFinish;
              wb_done_q <= 1'b1;
`ifdef WB_STREAM_EN
              m_valid_q <= 1'b0;
              m_data_q  <= '0;
              m_last_q  <= 1'b0;
`endif
            end else begin
              idx_q     <= idx_q + 1'b1;
`ifdef WB_STREAM_EN
              m_data_q  <= snap_q[idx_q + 1'b1];
              m_last_q  <= (idx_q == IdxW'(NumEl - 2));
`endif
            end
          end
        end
        StFinish: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Snapshot buffer: loaded only on an accepted done_i.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < NumEl; k++) begin
        snap_q[k] <= res_i[k*DATA_W +: DATA_W];
      end
    end
  end

  // Result memory is never cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= snap_q[idx_q];
  end

  // Read-first: a same-cycle write to rd_addr is seen one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= mem[rd_addr];
  end

  assign rd_data  = rd_data_q;
  assign busy     = busy_q;
  assign wb_done  = wb_done_q;
  assign overflow = overflow_q;

endmodule
